// File: rtl/regfile_arb_pkg.sv
// Shared constants, command encoding and round-robin pick helper for the
// register-file arbiter and its storage.
package regfile_arb_pkg;

    localparam int RF_DW    = 8;
    localparam int RF_DEPTH = 4;
    localparam int RF_AW    = 2;

    // The pick helper works on a fixed-width vector wide enough for the
    // largest supported requester count; unused upper bits are tied low.
    localparam int MAX_REQ = 8;
    localparam int PICK_W  = 3;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First set bit of eligible at or after ptr, wrapping modulo num.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] eligible,
        input logic [PICK_W-1:0]  ptr,
        input int                 num
    );
        pick_t             res;
        logic [PICK_W-1:0] cand;
        int                sum;
        res  = '0;
        cand = '0;
        sum  = 0;
        for (int k = 0; k < MAX_REQ; k++) begin
            sum  = (int'(ptr) + k) % num;
            cand = PICK_W'(sum);
            if ((k < num) && !res.found && eligible[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_we.sv
// DEPTH x DW register storage with a synchronous write-enabled port and a
// combinational read port; out-of-range reads return zero.
module regfile_we
    import regfile_arb_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem_reg[raddr];
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between NUM_REQ requesters,
// with a single tagged, backpressured read-response channel.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = RF_DW,
    parameter int DEPTH   = RF_DEPTH,
    parameter int AW      = RF_AW,
    parameter int IDW     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_rdata,
    input  logic                  rsp_ready
);

    logic [IDW-1:0]     rr_ptr_reg;
    logic [IDW-1:0]     rr_ptr_next;
    logic               rsp_valid_reg;
    logic [IDW-1:0]     rsp_id_reg;
    logic [DW-1:0]      rsp_rdata_reg;

    logic [AW-1:0]      addr_arr  [NUM_REQ];
    logic [DW-1:0]      wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [MAX_REQ-1:0] elig_wide;
    logic               rsp_hold;
    pick_t              pick;
    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    cmd_e               sel_cmd;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               addr_ok;
    logic               wr_en;
    logic               rd_xfer;
    logic [DW-1:0]      rd_data;

    // A stalled response blocks further reads; writes never touch the
    // response register so they keep flowing.
    assign rsp_hold = rsp_valid_reg & ~rsp_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
            assign eligible[gi]  = req_valid[gi] & (req_write[gi] | ~rsp_hold);
            assign req_ready[gi] = gnt_found & (pick.idx == PICK_W'(gi));
        end
    endgenerate

    always_comb begin
        elig_wide                = '0;
        elig_wide[NUM_REQ-1:0]   = eligible;
    end

    assign pick      = rr_pick(elig_wide, PICK_W'(rr_ptr_reg), NUM_REQ);
    assign gnt_found = pick.found & ~reset;
    assign gnt_idx   = IDW'(pick.idx);

    assign sel_cmd   = cmd_e'(req_write[gnt_idx]);
    assign sel_addr  = addr_arr[gnt_idx];
    assign sel_wdata = wdata_arr[gnt_idx];
    assign addr_ok   = (int'(sel_addr) < DEPTH);

    // Out-of-range writes still handshake but leave storage untouched.
    assign wr_en   = gnt_found & (sel_cmd == CMD_WRITE) & addr_ok;
    assign rd_xfer = gnt_found & (sel_cmd == CMD_READ);

    regfile_we #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (sel_addr),
        .wdata (sel_wdata),
        .raddr (sel_addr),
        .rdata (rd_data)
    );

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (gnt_found) begin
            if (int'(gnt_idx) == NUM_REQ - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = gnt_idx + IDW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // A new read overwrites the slot even when the old response is being
    // accepted this cycle, giving one read per cycle with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_rdata_reg <= '0;
        end else if (rd_xfer) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= gnt_idx;
            rsp_rdata_reg <= rd_data;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a cycle-level reference model checks every
// cycle, and literal expectations pin the scenarios of interest.
module tb_regfile_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_write = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_ready = 1'b1;

    regfile_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: storage array, pointer and a single response slot.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr   = 0;
    bit            m_rv    = 1'b0;
    int            m_rid   = 0;
    logic [DW-1:0] m_rdata = '0;
    bit            mon_en  = 1'b0;
    int            grant_log [$];
    int            rsp_log   [$];

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    always @(negedge clk) begin
        int                 exp_g;
        bit                 hold;
        logic [NUM_REQ-1:0] exp_ready;
        int                 a;
        int                 c;
        if (mon_en) begin
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
            if (m_rv) begin
                check("rsp_id", {30'd0, rsp_id}, m_rid);
                check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, m_rdata});
            end
            exp_g = -1;
            hold  = m_rv && !rsp_ready;
            if (!reset) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (exp_g < 0 && req_valid[c] && (req_write[c] || !hold)) exp_g = c;
                end
            end
            exp_ready = '0;
            if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
            check("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
            for (int k = 0; k < NUM_REQ; k++)
                if (!reset && req_ready[k]) grant_log.push_back(k);
            if (!reset && rsp_valid && rsp_ready) begin
                rsp_log.push_back(int'(rsp_id) * 256 + int'(rsp_rdata));
                $display("rsp  id=%0d rdata=0x%02h t=%0t", rsp_id, rsp_rdata, $time);
            end
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                m_ptr = 0;
                m_rv  = 1'b0;
            end else begin
                if (rsp_ready) m_rv = 1'b0;
                if (exp_g >= 0) begin
                    a = int'(req_addr[exp_g*AW +: AW]);
                    if (req_write[exp_g]) begin
                        m_mem[a] = req_wdata[exp_g*DW +: DW];
                        $display("gnt  req%0d write addr=%0d wdata=0x%02h t=%0t", exp_g, a, m_mem[a], $time);
                    end else begin
                        m_rv    = 1'b1;
                        m_rid   = exp_g;
                        m_rdata = m_mem[a];
                        $display("gnt  req%0d read  addr=%0d t=%0t", exp_g, a, $time);
                    end
                    m_ptr = (exp_g + 1) % NUM_REQ;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int a, input int d);
        req_valid[i]           = v;
        req_write[i]           = w;
        req_addr[i*AW +: AW]   = AW'(a);
        req_wdata[i*DW +: DW]  = DW'(d);
    endtask

    // Hold each command until its handshake, then drop it.
    task automatic issue_until_done(input int bound);
        int                 n;
        logic [NUM_REQ-1:0] g;
        n = 0;
        while (req_valid != '0 && n < bound) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
            n++;
        end
        check("issue_done", {28'd0, req_valid}, 32'd0);
    endtask

    task automatic read_word(input int id, input int addr, input int exp, input string tag);
        set_req(id, 1'b1, 1'b0, addr, 0);
        issue_until_done(20);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_id"}, {30'd0, rsp_id}, id);
        check({tag, "_data"}, {24'd0, rsp_rdata}, exp);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b0;

        // Test 1: cleared storage reads back zero
        for (int a = 0; a < DEPTH; a++) read_word(0, a, 8'h00, "t1_rd");

        // Test 2: simultaneous writes granted in index order
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, i, 8'h10 + i);
        issue_until_done(20);
        check("t2_ngrant", grant_log.size(), 32'd4);
        if (grant_log.size() == 4)
            for (int k = 0; k < 4; k++) check("t2_grant", grant_log[k], k);
        for (int a = 0; a < DEPTH; a++) read_word(0, a, 8'h10 + a, "t2_rd");

        // Test 3: alternating continuous reads from 3 and 1, pointer at 2
        read_word(1, 0, 8'h10, "t3_pre");
        grant_log.delete();
        rsp_log.delete();
        set_req(1, 1'b1, 1'b0, 1, 0);
        set_req(3, 1'b1, 1'b0, 3, 0);
        repeat (4) tick();
        req_valid = '0;
        tick();
        check("t3_ngrant", grant_log.size(), 32'd4);
        check("t3_nrsp", rsp_log.size(), 32'd4);
        if (grant_log.size() == 4 && rsp_log.size() == 4) begin
            check("t3_g0", grant_log[0], 32'd3);
            check("t3_g1", grant_log[1], 32'd1);
            check("t3_g2", grant_log[2], 32'd3);
            check("t3_g3", grant_log[3], 32'd1);
            check("t3_r0", rsp_log[0], 32'h313);
            check("t3_r1", rsp_log[1], 32'h111);
            check("t3_r2", rsp_log[2], 32'h313);
            check("t3_r3", rsp_log[3], 32'h111);
        end
        tick();

        // Test 4: stalled response lets writes through and holds its data
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 2, 0);
        issue_until_done(20);
        set_req(0, 1'b1, 1'b0, 2, 0);
        set_req(1, 1'b1, 1'b1, 2, 8'hAB);
        @(negedge clk);
        check("t4_gnt_wr", {28'd0, req_ready}, 32'b0010);
        check("t4_hold0", {24'd0, rsp_rdata}, 32'h12);
        tick();
        set_req(1, 1'b0, 1'b1, 2, 8'hAB);
        @(negedge clk);
        check("t4_stall", {28'd0, req_ready}, 32'd0);
        check("t4_hold_v", {31'd0, rsp_valid}, 32'd1);
        check("t4_hold1", {24'd0, rsp_rdata}, 32'h12);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_gnt_rd", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t4_new_v", {31'd0, rsp_valid}, 32'd1);
        check("t4_new_id", {30'd0, rsp_id}, 32'd0);
        check("t4_new_data", {24'd0, rsp_rdata}, 32'hAB);
        tick();

        // Test 5: read and write to the same word, read first sees old value
        read_word(3, 0, 8'h10, "t5_pre");
        grant_log.delete();
        rsp_log.delete();
        set_req(0, 1'b1, 1'b0, 1, 0);
        set_req(1, 1'b1, 1'b1, 1, 8'h55);
        issue_until_done(20);
        tick();
        check("t5_ngrant", grant_log.size(), 32'd2);
        check("t5_nrsp", rsp_log.size(), 32'd1);
        if (grant_log.size() == 2 && rsp_log.size() == 1) begin
            check("t5_g0", grant_log[0], 32'd0);
            check("t5_g1", grant_log[1], 32'd1);
            check("t5_old", rsp_log[0], 32'h011);
        end
        read_word(0, 1, 8'h55, "t5_new");

        // Test 6: reset with a stalled response pending
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 1'b0, 3, 0);
        issue_until_done(20);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, i, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", {28'd0, req_ready}, 32'd0);
        check("t6_pend_v", {31'd0, rsp_valid}, 32'd1);
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        grant_log.delete();
        rsp_log.delete();
        @(negedge clk);
        check("t6_cleared_v", {31'd0, rsp_valid}, 32'd0);
        check("t6_first", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        issue_until_done(20);
        tick();
        check("t6_ngrant", grant_log.size(), 32'd4);
        check("t6_nrsp", rsp_log.size(), 32'd4);
        if (grant_log.size() == 4 && rsp_log.size() == 4)
            for (int k = 0; k < 4; k++) begin
                check("t6_grant", grant_log[k], k);
                check("t6_rsp", rsp_log[k], k * 256);
            end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
